// File: rtl/seq_serializer_pkg.sv
// Shared definitions for the parallel-to-serial front end of mealy_seq.
package seq_serializer_pkg;

  // Serializer FSM encoding
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bits needed to count 0..value-1 (value >= 2)
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_serializer.sv
// Parallel-to-serial converter with a one-word hold buffer so that
// back-to-back words leave as a contiguous bit stream on x_out.
module seq_serializer
  import seq_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             x_last
);

  localparam int unsigned    CW      = clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_TOP = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q,  hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] shifted;
  logic             accept;

  // Handshake and serial outputs, all decoded from registered state
  assign load_ready = !hold_full_q && !reset;
  assign accept     = load_valid && load_ready;
  assign x_valid    = (state_q == SHIFT);
  assign x_last     = (state_q == SHIFT) && (cnt_q == '0);
  assign x_out      = (state_q == SHIFT) ? (MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0])
                                         : IDLE_BIT;

  // Shift register advanced one position toward the output end
  always_comb begin
    shifted = '0;
    if (MSB_FIRST) begin
      shifted = {shift_q[WIDTH-2:0], 1'b0};
    end else begin
      shifted = {1'b0, shift_q[WIDTH-1:1]};
    end
  end

  // Next-state logic: load, shift, hold fill, hold drain and bypass
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d = data_in;
          cnt_d   = CNT_TOP;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          shift_d = shifted;
          cnt_d   = cnt_q - 1'b1;
          if (accept) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
          end
        end else if (hold_full_q) begin
          // accept cannot coincide here: load_ready is low while the hold is full
          shift_d     = hold_q;
          cnt_d       = CNT_TOP;
          hold_full_d = 1'b0;
        end else if (accept) begin
          // word offered on the last bit goes straight into the shifter
          shift_d = data_in;
          cnt_d   = CNT_TOP;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_seq_serializer.sv
// Scoreboard bench: accepted words are expanded into expected bits on a
// queue; each cycle the serial output is popped and compared.
module tb_seq_serializer;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  localparam bit IDLE4 = 1'b0;
  localparam bit IDLE8 = 1'b1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] d4  = '0;
  logic [7:0] d8  = '0;
  logic       lv4 = 1'b0;
  logic       lv8 = 1'b0;
  logic       ready4, xo4, xv4, xl4;
  logic       ready8, xo8, xv8, xl8;

  exp_t q4[$];
  exp_t q8[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  seq_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(IDLE4)) u4 (
    .clock(clk), .reset(rst), .data_in(d4), .load_valid(lv4),
    .load_ready(ready4), .x_out(xo4), .x_valid(xv4), .x_last(xl4)
  );

  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(IDLE8)) u8 (
    .clock(clk), .reset(rst), .data_in(d8), .load_valid(lv8),
    .load_ready(ready8), .x_out(xo8), .x_valid(xv8), .x_last(xl8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Per-cycle stream check of the 4-bit MSB-first instance
  always @(negedge clk) begin
    exp_t e;
    check("x4_valid", xv4, (q4.size() != 0));
    if (xv4 === 1'b1 && q4.size() != 0) begin
      e = q4.pop_front();
      check("x4_bit", xo4, e.b);
      check("x4_last", xl4, e.last);
    end else begin
      check("x4_idle", xo4, IDLE4);
      check("x4_idle_last", xl4, 1'b0);
    end
    // a second word is held exactly when more than one word's bits remain
    check("ready4", ready4, (!rst && q4.size() < 4));
  end

  // Per-cycle stream check of the 8-bit LSB-first instance
  always @(negedge clk) begin
    exp_t e;
    check("x8_valid", xv8, (q8.size() != 0));
    if (xv8 === 1'b1 && q8.size() != 0) begin
      e = q8.pop_front();
      check("x8_bit", xo8, e.b);
      check("x8_last", xl8, e.last);
    end else begin
      check("x8_idle", xo8, IDLE8);
      check("x8_idle_last", xl8, 1'b0);
    end
    check("ready8", ready8, (!rst && q8.size() < 8));
  end

  // All driver tasks start and end at negedge+1
  task automatic step(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic idle4(input int unsigned n);
    lv4 = 1'b0;
    repeat (n) begin
      d4 = 4'($urandom);
      step(1);
    end
  endtask

  task automatic idle8(input int unsigned n);
    lv8 = 1'b0;
    repeat (n) begin
      d8 = 8'($urandom);
      step(1);
    end
  endtask

  // Offer a word until accepted; data scrambled while stalled
  task automatic send4(input logic [3:0] w);
    int unsigned guard = 0;
    exp_t e;
    lv4 = 1'b1;
    d4  = ~w;
    while (ready4 !== 1'b1 && guard < 64) begin
      step(1);
      d4 = 4'($urandom);
      guard++;
    end
    if (ready4 !== 1'b1) begin
      check("ready4_timeout", ready4, 1'b1);
      lv4 = 1'b0;
    end else begin
      d4 = w;
      for (int i = 3; i >= 0; i--) begin
        e.b    = w[i];
        e.last = (i == 0);
        q4.push_back(e);
      end
      step(1);
    end
  endtask

  task automatic send8(input logic [7:0] w);
    int unsigned guard = 0;
    exp_t e;
    lv8 = 1'b1;
    d8  = ~w;
    while (ready8 !== 1'b1 && guard < 64) begin
      step(1);
      d8 = 8'($urandom);
      guard++;
    end
    if (ready8 !== 1'b1) begin
      check("ready8_timeout", ready8, 1'b1);
      lv8 = 1'b0;
    end else begin
      d8 = w;
      for (int i = 0; i < 8; i++) begin
        e.b    = w[i];
        e.last = (i == 7);
        q8.push_back(e);
      end
      step(1);
    end
  endtask

  initial begin
    step(2);
    rst = 1'b0;
    idle4(2);

    // Single word from idle: 1,0,0,1 then idle
    send4(4'b1001);
    check("first_bit", xo4, 1'b1);
    check("first_valid", xv4, 1'b1);
    idle4(6);

    // Back-to-back through the hold buffer
    send4(4'b1001);
    send4(4'b0100);
    check("hold_ready", ready4, 1'b0);
    idle4(10);

    // Bypass: next word offered exactly on the last bit
    send4(4'b0011);
    idle4(3);
    check("bypass_last", xl4, 1'b1);
    send4(4'b1100);
    idle4(8);

    // Stall: three words with valid held high
    send4(4'b1110);
    send4(4'b0101);
    send4(4'b0011);
    idle4(14);

    // Reset after two bits of 1010, with a load offered during reset
    send4(4'b1010);
    idle4(1);
    rst = 1'b1;
    lv4 = 1'b1;
    d4  = 4'hF;
    q4.delete();
    q8.delete();
    #1;
    check("rst_ready", ready4, 1'b0);
    step(1);
    check("rst_xout", xo4, IDLE4);
    check("rst_xvalid", xv4, 1'b0);
    rst = 1'b0;
    lv4 = 1'b0;
    #1;
    check("post_rst_ready", ready4, 1'b1);
    idle4(4);

    // LSB-first 8-bit word 0x96 -> 0,1,1,0,1,0,0,1
    send8(8'h96);
    check("lsb_first_bit", xo8, 1'b0);
    idle8(10);

    // Random words with random gaps, including back-to-back runs
    for (int k = 0; k < 8; k++) begin
      send8(8'($urandom));
      if ($urandom_range(0, 1) == 1) idle8($urandom_range(0, 9));
    end
    idle8(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_serializer.md
Name: seq_serializer

Overview:
Parallel-to-serial front end that feeds the serial input `x` of the mealy_seq sequence detector, one bit per clock.
- Accepts WIDTH-bit words over a valid/ready handshake.
- Holds one word in the shift register and buffers a second word, so back-to-back words stream with no idle bit between them.
- Drives IDLE_BIT on `x` whenever no word is shifting.

Parameters:
WIDTH, 8, bits per word (≥2)
MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = bit 0 first
IDLE_BIT, 0, value on x_out when x_valid=0

Ports:
clock  in  1  rising-edge clock, shared with mealy_seq
reset  in  1  synchronous, active-high reset
data_in  in  WIDTH  word to serialize
load_valid  in  1  data_in is valid
load_ready  out  1  block can accept a word this cycle
x_out  out  1  serial bit, connects to mealy_seq x
x_valid  out  1  x_out carries a word bit
x_last  out  1  x_out is the final bit of the current word

Behaviour:
- Clocking and reset:
  - One clock domain; reset is synchronous and active-high; all state updates on the rising edge of clock.
  - Reset values: state=IDLE, hold_full=0, cnt=0, x_out=IDLE_BIT, x_valid=0, x_last=0.
  - load_ready=0 in any cycle where reset=1. Loads offered during reset are dropped.
- State:
  - shift_reg[WIDTH], cnt (clog2(WIDTH) bits, bits remaining after the current one), hold_reg[WIDTH], hold_full.
  - FSM states: IDLE, SHIFT.
- Registered outputs and handshake:
  - x_out = shift_reg[WIDTH-1] if MSB_FIRST, else shift_reg[0]; forced to IDLE_BIT in IDLE.
  - x_valid = (state==SHIFT); x_last = (state==SHIFT && cnt==0).
  - load_ready = !hold_full && !reset (combinational from registers).
  - Accept = load_valid && load_ready at a rising edge.
- IDLE:
  - On accept: shift_reg<=data_in, cnt<=WIDTH-1, state<=SHIFT.
  - Latency: the first bit appears on x_out in the cycle right after the accept edge.
- SHIFT, cnt≠0:
  - Each edge: shift_reg shifts by one toward the output end; cnt<=cnt-1.
  - An accept in this state writes hold_reg and sets hold_full=1.
- SHIFT, cnt==0 (last bit on x_out), next edge:
  - If hold_full: shift_reg<=hold_reg, cnt<=WIDTH-1, hold_full<=0, stay in SHIFT.
  - Else if accept (the bypass path): shift_reg<=data_in, cnt<=WIDTH-1, stay in SHIFT.
  - Else: state<=IDLE, so x_out=IDLE_BIT and x_valid=0 next cycle.
- Back-to-back words give a contiguous bit stream: zero gap cycles between the last bit of word N and the first bit of word N+1.
- Simultaneous accept and hold drain at the cnt==0 edge cannot occur, because load_ready=0 while hold_full=1. Bench asserts this.
- Maximum occupancy is 2 words (shifting + held); a third word stalls with load_ready=0.
- Reset during a word:
  - Both words are discarded and no partial bits continue.
  - x_out=IDLE_BIT in the cycle after the reset edge.
- data_in is sampled only at the accept edge; changes at other times have no effect.

Decomposition:
- Shared package: FSM state encoding (IDLE=1'b0, SHIFT=1'b1) and a count-width function clog2(WIDTH).
- No sub-module. The hold buffer is a single register plus a flag, kept inline.
- A stream-level wrapper pairing seq_serializer → mealy_seq is a separate integration bench, not part of this block.

Test Plan:
- WIDTH=4, MSB_FIRST=1, accept 4'b1001 at t=10 from IDLE → x_out 1,0,0,1 on the next 4 cycles; x_valid=1 for those 4 cycles; x_last=1 only on the 4th; then x_out=0, x_valid=0.
- Back-to-back: accept 4'b1001, then 4'b0100 while the first is shifting → x_out 1,0,0,1,0,1,0,0 with no gap; load_ready=0 from the edge the hold fills until the cnt==0 drain edge.
- Bypass: accept 4'b1100 exactly in the x_last cycle of 4'b0011 with the hold empty → 0,0,1,1,1,1,0,0 contiguous; hold_full never asserts.
- Stall: load_valid held high with three words → third word accepted only after the first word's last bit; no word is lost or duplicated (scoreboard on the bit stream).
- Reset mid-word: reset=1 for one cycle after 2 bits of 4'b1010 → x_out=IDLE_BIT and x_valid=0 the next cycle; hold empty; load_ready=0 during the reset cycle and 1 after it.
- MSB_FIRST=0, WIDTH=8, word 8'h96 → x_out 0,1,1,0,1,0,0,1; downstream mealy_seq z matches the golden model for the same bit stream.
